func_seq_ctrl: RTL and testbench
================================

// Module: func_seq_ctrl
// PURPOSE
//  Playlist sequencer for the digital function generator. Holds a table of (func code, dwell)
//  entries, steps through them on start and drives the generator's 3-bit func select.
//  Sits between the front-panel/config logic and the generator.
//  Supports one-shot and looped playback, with per-segment and end-of-run strobes for the scope capture path.
// PARAMETERS
//  DEPTH      8   number of playlist entries (power of 2)
//  ADDR_W     3   log2(DEPTH)
//  DWELL_W    16  dwell counter width
//  IDLE_FUNC  3'd7  func code driven whenever not running
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        asynchronous, active-low reset
//  cfg_we     in   1        write one table entry this cycle
//  cfg_addr   in   ADDR_W   entry index for cfg_we
//  cfg_func   in   3        func code stored at cfg_addr
//  cfg_dwell  in   DWELL_W  dwell stored at cfg_addr; segment lasts cfg_dwell+1 cycles
//  cfg_len_we in   1        write playlist length
//  cfg_len    in   ADDR_W+1 number of active entries, 0..DEPTH (values >DEPTH clamp to DEPTH)
//  loop_en    in   1        1: wrap to entry 0 after last entry; sampled at end of last segment
//  start      in   1        level/pulse; begins playback from entry 0 when IDLE
//  stop       in   1        aborts playback
//  func       out  3        func select to generator
//  busy       out  1        1 while state RUN
//  entry_idx  out  ADDR_W   index of entry currently driven
//  seg_start  out  1        1-cycle pulse on first cycle of every segment
//  done       out  1        1-cycle pulse when one-shot playback completes
//  trig       out  1        scope trigger (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, func=IDLE_FUNC, busy=0, entry_idx=0, seg_start=0,
//    done=0, trig=0, dwell counter=0, len=0. Table contents reset to func=IDLE_FUNC, dwell=0.
//  - States: IDLE, RUN. All outputs registered.
//  - IDLE: if start=1, stop=0, len!=0 -> next cycle RUN, entry_idx=0, func=tbl[0].func,
//    seg_start=1, dwell counter loaded with tbl[0].dwell. If len==0, start is ignored.
//  - RUN: counter decrements each cycle. In the cycle where counter==0 (last cycle of segment):
//    - if entry_idx < len-1: next cycle entry_idx+1 loads, seg_start=1.
//    - else if loop_en=1: next cycle entry 0 loads, seg_start=1.
//    - else: next cycle IDLE, func=IDLE_FUNC, busy=0, done=1 for that one cycle.
//  - Entry fields are latched at segment load. cfg_we to the active entry takes effect
//    next time that entry loads. cfg_len_we during RUN takes effect at the next boundary
//    check; if new len <= entry_idx, the current segment is treated as last.
//  - stop=1 has priority over start and over segment advance. In RUN: next cycle IDLE,
//    func=IDLE_FUNC, entry_idx=0, no done pulse. In IDLE: start is ignored.
//  - start while RUN is ignored (no restart).
//  - Dwell 0: segment is exactly 1 cycle. seg_start can be high on consecutive cycles.
//  - cfg_we and playback in the same cycle to the same entry: the load uses the old value.
//  - Latency: func changes 1 cycle after the sampling edge. The generator adds 1 more register
//    stage, so the generator output reflects the new func 2 cycles after the decision edge.
// CONFIGURATION
//  FUNC_SEQ_TRIG_EN defined: trig = seg_start delayed 1 cycle, aligned with the first
//    generator sample of each segment. This adds one flop, which resets to 0.
//  FUNC_SEQ_TRIG_EN undefined: trig is tied to 0. The port remains present.
// TESTING
//  1. Reset mid-RUN (reset low 1 cycle) -> func=7, busy=0, entry_idx=0 immediately (async),
//     table cleared. A start with len=0 afterwards has no effect.
//  2. Load {2,d3},{1,d0},{4,d1}; len=3, loop_en=0, start pulse -> func sequence
//     2,2,2,2,1,4,4 then 7. seg_start on cycles 1,5,6; done=1 on cycle 8; busy low on cycle 8.
//  3. Same table, loop_en=1 -> after 4,4 it returns to 2 with seg_start=1 and entry_idx=0.
//     Runs 3 full loops with no done pulse.
//  4. stop asserted in cycle 2 of entry 0 -> next cycle func=7, busy=0, done stays 0.
//     start+stop together in IDLE -> stays IDLE.
//  5. During RUN on entry 1, write entry 1 dwell=d5 and set len=2 -> the current segment is
//     unchanged. The next loop uses dwell 5, and entry 2 is never played.
//  6. With FUNC_SEQ_TRIG_EN: trig pulses exactly 1 cycle after each seg_start.
//     Without it: trig stays 0 for the whole of test 2.

Source files
------------

// File: rtl/func_seq_ctrl.sv
// func_seq_ctrl: playlist sequencer for the digital function generator.
// Steps through a table of (func, dwell) entries and drives the generator's
// 3-bit func select, with per-segment and end-of-run strobes.
// Optional feature macro: FUNC_SEQ_TRIG_EN (trig = seg_start delayed 1 cycle;
// when undefined trig is tied to 0).
module func_seq_ctrl #(
   parameter int         DEPTH     = 8,
   parameter int         ADDR_W    = 3,
   parameter int         DWELL_W   = 16,
   parameter logic [2:0] IDLE_FUNC = 3'd7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [2:0]         cfg_func,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_len_we,
   input  logic [ADDR_W:0]    cfg_len,
   input  logic               loop_en,
   input  logic               start,
   input  logic               stop,
   output logic [2:0]         func,
   output logic               busy,
   output logic [ADDR_W-1:0]  entry_idx,
   output logic               seg_start,
   output logic               done,
   output logic               trig
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [2:0]         tbl_func  [DEPTH];
   logic [DWELL_W-1:0] tbl_dwell [DEPTH];
   logic [ADDR_W:0]    len, len_eff;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [2:0]         func_nxt;
   logic [ADDR_W-1:0]  idx_nxt, load_idx;
   logic               seg_nxt, done_nxt, do_load;

   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] v);
      return (v > DEPTH_L) ? DEPTH_L : v;
   endfunction

   // A length written in the same cycle as a boundary check already governs that check.
   assign len_eff = cfg_len_we ? clamp_len(cfg_len) : len;
   assign busy    = (state == RUN);

   // Playlist table and length storage; a load in the same cycle as a write sees the old entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_func[i]  <= IDLE_FUNC;
            tbl_dwell[i] <= '0;
         end
         len <= '0;
      end else begin
         if (cfg_we) begin
            tbl_func[cfg_addr]  <= cfg_func;
            tbl_dwell[cfg_addr] <= cfg_dwell;
         end
         if (cfg_len_we) len <= clamp_len(cfg_len);
      end
   end

   // Next-state and next-output decode; stop outranks start and segment advance.
   always_comb begin
      state_nxt = state;
      func_nxt  = func;
      idx_nxt   = entry_idx;
      cnt_nxt   = cnt;
      seg_nxt   = 1'b0;
      done_nxt  = 1'b0;
      do_load   = 1'b0;
      load_idx  = '0;
      case (state)
         IDLE: begin
            func_nxt = IDLE_FUNC;
            idx_nxt  = '0;
            if (start && !stop && (len_eff != '0)) begin
               state_nxt = RUN;
               do_load   = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
               func_nxt  = IDLE_FUNC;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               if (({1'b0, entry_idx} + 1'b1) < len_eff) begin
                  do_load  = 1'b1;
                  load_idx = entry_idx + 1'b1;
               end else if (loop_en) begin
                  do_load  = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  func_nxt  = IDLE_FUNC;
                  idx_nxt   = '0;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (do_load) begin
         func_nxt = tbl_func[load_idx];
         idx_nxt  = load_idx;
         cnt_nxt  = tbl_dwell[load_idx];
         seg_nxt  = 1'b1;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         func      <= IDLE_FUNC;
         entry_idx <= '0;
         cnt       <= '0;
         seg_start <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         func      <= func_nxt;
         entry_idx <= idx_nxt;
         cnt       <= cnt_nxt;
         seg_start <= seg_nxt;
         done      <= done_nxt;
      end
   end

`ifdef FUNC_SEQ_TRIG_EN
   // Trigger lines up with the first generator sample of each segment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) trig <= 1'b0;
      else        trig <= seg_start;
   end
`else
   assign trig = 1'b0;
`endif

endmodule

// File: tb/tb_func_seq_ctrl.sv
// Testbench for func_seq_ctrl: directed vector table, reset corner case and
// randomized playback episodes checked against a playlist-expansion model.
module tb_func_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we, cfg_len_we, loop_en, start, stop;
   logic [2:0]  cfg_addr, cfg_func;
   logic [15:0] cfg_dwell;
   logic [3:0]  cfg_len;
   logic [2:0]  func, entry_idx;
   logic        busy, seg_start, done, trig;

   func_seq_ctrl dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_func(cfg_func), .cfg_dwell(cfg_dwell), .cfg_len_we(cfg_len_we),
      .cfg_len(cfg_len), .loop_en(loop_en), .start(start), .stop(stop),
      .func(func), .busy(busy), .entry_idx(entry_idx), .seg_start(seg_start),
      .done(done), .trig(trig)
   );

   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   logic prev_seg = 1'b0;

   typedef struct {
      logic we; logic [2:0] addr; logic [2:0] cf; logic [15:0] dw;
      logic lwe; logic [3:0] len; logic lp; logic st; logic sp;
      logic [2:0] ef; logic eb; logic [2:0] ei; logic es; logic ed;
   } vec_t;
   vec_t tab[$];

   typedef struct { logic [2:0] f; logic [2:0] i; logic s; } rec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] ef, input logic eb,
                           input logic [2:0] ei, input logic es, input logic ed);
      logic et;
`ifdef FUNC_SEQ_TRIG_EN
      et = prev_seg;
`else
      et = 1'b0;
`endif
      chk($sformatf("%s.func", tag), 32'(func), 32'(ef));
      chk($sformatf("%s.busy", tag), 32'(busy), 32'(eb));
      chk($sformatf("%s.idx", tag), 32'(entry_idx), 32'(ei));
      chk($sformatf("%s.seg", tag), 32'(seg_start), 32'(es));
      chk($sformatf("%s.done", tag), 32'(done), 32'(ed));
      chk($sformatf("%s.trig", tag), 32'(trig), 32'(et));
      prev_seg = es;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_we = 0; cfg_addr = 0; cfg_func = 0; cfg_dwell = 0;
      cfg_len_we = 0; cfg_len = 0; loop_en = 0; start = 0; stop = 0;
   endtask

   function automatic void add(input logic we, input logic [2:0] addr, input logic [2:0] cf,
                               input logic [15:0] dw, input logic lwe, input logic [3:0] len,
                               input logic lp, input logic st, input logic sp,
                               input logic [2:0] ef, input logic eb, input logic [2:0] ei,
                               input logic es, input logic ed);
      vec_t v;
      v.we = we; v.addr = addr; v.cf = cf; v.dw = dw; v.lwe = lwe; v.len = len;
      v.lp = lp; v.st = st; v.sp = sp; v.ef = ef; v.eb = eb; v.ei = ei; v.es = es; v.ed = ed;
      tab.push_back(v);
   endfunction

   function automatic void cfgw(input logic [2:0] a, input logic [2:0] f, input logic [15:0] d);
      add(1, a, f, d, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0);
   endfunction

   function automatic void lenw(input logic [3:0] l);
      add(0, 0, 0, 0, 1, l, 0, 0, 0, 3'd7, 0, 0, 0, 0);
   endfunction

   function automatic void run(input logic lp, input logic st, input logic sp, input logic [2:0] ef,
                               input logic eb, input logic [2:0] ei, input logic es, input logic ed);
      add(0, 0, 0, 0, 0, 0, lp, st, sp, ef, eb, ei, es, ed);
   endfunction

   logic [2:0]  m_func [8];
   logic [15:0] m_dwell [8];
   int          m_len;

   initial begin
      logic [2:0] pf [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd4, 3'd4};
      logic [2:0] pi [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
      logic       ps [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      rec_t q[$];
      rec_t r;

      // Basic one-shot playlist: 2 for 4 cycles, 1 for 1, 4 for 2, then done.
      cfgw(0, 2, 3); cfgw(1, 1, 0); cfgw(2, 4, 1); lenw(3);
      run(0, 1, 0, 2, 1, 0, 1, 0);
      for (int k = 0; k < 3; k++) run(0, 0, 0, 2, 1, 0, 0, 0);
      run(0, 0, 0, 1, 1, 1, 1, 0);
      run(0, 0, 0, 4, 1, 2, 1, 0);
      run(0, 0, 0, 4, 1, 2, 0, 0);
      run(0, 0, 0, 7, 0, 0, 0, 1);
      run(0, 0, 0, 7, 0, 0, 0, 0);
      // Looped playback: three full passes, no done, then stop after the wrap.
      for (int l = 0; l < 3; l++)
         for (int c = 0; c < 7; c++)
            run(1, (l == 0 && c == 0), 0, pf[c], 1, pi[c], ps[c], 0);
      run(1, 0, 0, 2, 1, 0, 1, 0);
      run(1, 0, 1, 7, 0, 0, 0, 0);
      // Stop in cycle 2 of entry 0, then start+stop together in IDLE.
      run(0, 1, 0, 2, 1, 0, 1, 0);
      run(0, 0, 0, 2, 1, 0, 0, 0);
      run(0, 0, 1, 7, 0, 0, 0, 0);
      run(0, 1, 1, 7, 0, 0, 0, 0);
      run(0, 0, 0, 7, 0, 0, 0, 0);
      // Rewrite entry 1 dwell and shrink len while entry 1 plays.
      run(1, 1, 0, 2, 1, 0, 1, 0);
      for (int k = 0; k < 3; k++) run(1, 0, 0, 2, 1, 0, 0, 0);
      run(1, 0, 0, 1, 1, 1, 1, 0);
      add(1, 1, 1, 5, 1, 2, 1, 0, 0, 2, 1, 0, 1, 0);
      for (int k = 0; k < 3; k++) run(1, 0, 0, 2, 1, 0, 0, 0);
      run(1, 0, 0, 1, 1, 1, 1, 0);
      for (int k = 0; k < 5; k++) run(1, 0, 0, 1, 1, 1, 0, 0);
      run(1, 0, 0, 2, 1, 0, 1, 0);
      run(1, 0, 1, 7, 0, 0, 0, 0);

      // Reset state.
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", 7, 0, 0, 0, 0);
      #2 reset = 1'b1;

      foreach (tab[n]) begin
         cfg_we = tab[n].we; cfg_addr = tab[n].addr; cfg_func = tab[n].cf;
         cfg_dwell = tab[n].dw; cfg_len_we = tab[n].lwe; cfg_len = tab[n].len;
         loop_en = tab[n].lp; start = tab[n].st; stop = tab[n].sp;
         cyc();
         chk_outs($sformatf("vec%0d", n), tab[n].ef, tab[n].eb, tab[n].ei, tab[n].es, tab[n].ed);
      end
      idle_inputs();

      // Asynchronous reset in the middle of a looped run.
      cfg_len_we = 1; cfg_len = 2; cyc(); chk_outs("rst_len", 7, 0, 0, 0, 0);
      cfg_len_we = 0; loop_en = 1; start = 1; cyc(); chk_outs("rst_run", 2, 1, 0, 1, 0);
      start = 0; cyc(); chk_outs("rst_run2", 2, 1, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      prev_seg = 1'b0;
      chk_outs("rst_async", 7, 0, 0, 0, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      loop_en = 0; start = 1; cyc(); chk_outs("rst_len0_start", 7, 0, 0, 0, 0);
      start = 0; cfg_len_we = 1; cfg_len = 1; cyc(); chk_outs("rst_setlen", 7, 0, 0, 0, 0);
      cfg_len_we = 0; start = 1; cyc(); chk_outs("rst_cleared", 7, 1, 0, 1, 0);
      start = 0; cyc(); chk_outs("rst_cleared_done", 7, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin m_func[i] = 3'd7; m_dwell[i] = 16'd0; end
      m_len = 1;

      // Randomized episodes: configure while idle, then play and compare to the expanded playlist.
      for (int ep = 0; ep < 30; ep++) begin
         int  ncfg, stop_at, sz;
         logic lp, sp0;
         ncfg = $urandom_range(1, 4);
         for (int c = 0; c < ncfg; c++) begin
            idle_inputs();
            cfg_we = 1'($urandom); cfg_addr = 3'($urandom); cfg_func = 3'($urandom);
            cfg_dwell = 16'($urandom_range(0, 5));
            cfg_len_we = 1'($urandom); cfg_len = 4'($urandom_range(0, 10));
            cyc();
            chk_outs($sformatf("ep%0d_cfg", ep), 7, 0, 0, 0, 0);
            if (cfg_we) begin m_func[cfg_addr] = cfg_func; m_dwell[cfg_addr] = cfg_dwell; end
            if (cfg_len_we) m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
         end
         q.delete();
         for (int e = 0; e < m_len; e++)
            for (int k = 0; k <= int'(m_dwell[e]); k++) begin
               r.f = m_func[e]; r.i = 3'(e); r.s = (k == 0);
               q.push_back(r);
            end
         sz = q.size();
         lp = 1'($urandom); sp0 = ($urandom_range(0, 4) == 0);
         idle_inputs();
         loop_en = lp; start = 1; stop = sp0;
         cyc();
         if (sp0 || sz == 0) begin
            chk_outs($sformatf("ep%0d_nostart", ep), 7, 0, 0, 0, 0);
            continue;
         end
         chk_outs($sformatf("ep%0d_t1", ep), q[0].f, 1, q[0].i, q[0].s, 0);
         if (lp) stop_at = $urandom_range(2, 40);
         else stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(2, sz + 1) : 0;
         for (int t = 2; t < 60; t++) begin
            start = 1'($urandom);
            stop = (t == stop_at);
            cyc();
            if (stop) begin
               chk_outs($sformatf("ep%0d_stop", ep), 7, 0, 0, 0, 0);
               break;
            end else if (!lp && t == sz + 1) begin
               chk_outs($sformatf("ep%0d_done", ep), 7, 0, 0, 0, 1);
               break;
            end else begin
               r = q[(t - 1) % sz];
               chk_outs($sformatf("ep%0d_t%0d", ep, t), r.f, 1, r.i, r.s, 0);
            end
         end
         idle_inputs();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
